// File: rtl/cam_lut_access_arb.sv
// Two-requester round-robin arbiter for the CAM/LUT controller register port.
// Holds a level request until acked, then drains stray duplicate acks.
module cam_lut_access_arb #(
    parameter int CMP_WIDTH      = 32,
    parameter int DATA_WIDTH     = 56,
    parameter int LUT_DEPTH_BITS = 4,
    parameter int TIMEOUT        = 64,
    parameter int DRAIN_CYCLES   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      a_req,
    input  logic                      a_wr,
    input  logic [LUT_DEPTH_BITS-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0]     a_wr_data,
    input  logic [CMP_WIDTH-1:0]      a_wr_cmp_data,
    input  logic [CMP_WIDTH-1:0]      a_wr_cmp_dmask,
    input  logic                      b_req,
    input  logic                      b_wr,
    input  logic [LUT_DEPTH_BITS-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0]     b_wr_data,
    input  logic [CMP_WIDTH-1:0]      b_wr_cmp_data,
    input  logic [CMP_WIDTH-1:0]      b_wr_cmp_dmask,
    output logic                      a_busy,
    output logic                      b_busy,
    output logic                      a_done,
    output logic                      b_done,
    output logic                      res_err,
    output logic [DATA_WIDTH-1:0]     res_data,
    output logic [CMP_WIDTH-1:0]      res_cmp_data,
    output logic [CMP_WIDTH-1:0]      res_cmp_dmask,
    output logic                      rd_req,
    output logic [LUT_DEPTH_BITS-1:0] rd_addr,
    input  logic                      rd_ack,
    input  logic [DATA_WIDTH-1:0]     rd_data,
    input  logic [CMP_WIDTH-1:0]      rd_cmp_data,
    input  logic [CMP_WIDTH-1:0]      rd_cmp_dmask,
    output logic                      wr_req,
    output logic [LUT_DEPTH_BITS-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0]     wr_data,
    output logic [CMP_WIDTH-1:0]      wr_cmp_data,
    output logic [CMP_WIDTH-1:0]      wr_cmp_dmask,
    input  logic                      wr_ack
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    typedef struct packed {
        logic                      wr;
        logic [LUT_DEPTH_BITS-1:0] addr;
        logic [DATA_WIDTH-1:0]     data;
        logic [CMP_WIDTH-1:0]      cmp;
        logic [CMP_WIDTH-1:0]      msk;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, DONE, DRAIN} state_t;

    state_t                    state_q, state_d;
    logic                      last_q, last_d;
    logic [TW-1:0]             cnt_q, cnt_d;
    logic [DW-1:0]             drn_q, drn_d;
    cmd_t                      a_cmd_q, a_cmd_d;
    cmd_t                      b_cmd_q, b_cmd_d;
    logic                      a_busy_q, a_busy_d;
    logic                      b_busy_q, b_busy_d;
    logic                      a_done_q, a_done_d;
    logic                      b_done_q, b_done_d;
    logic                      err_q, err_d;
    logic [DATA_WIDTH-1:0]     rdat_q, rdat_d;
    logic [CMP_WIDTH-1:0]      rcmp_q, rcmp_d;
    logic [CMP_WIDTH-1:0]      rmsk_q, rmsk_d;
    logic                      rd_req_q, rd_req_d;
    logic                      wr_req_q, wr_req_d;
    logic [LUT_DEPTH_BITS-1:0] rd_addr_q, rd_addr_d;
    logic [LUT_DEPTH_BITS-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]     wdat_q, wdat_d;
    logic [CMP_WIDTH-1:0]      wcmp_q, wcmp_d;
    logic [CMP_WIDTH-1:0]      wmsk_q, wmsk_d;

    logic sel_b;
    logic ack;
    logic tmo;
    cmd_t gcmd;

    // last_q: 0 = A, 1 = B; on a tie the other requester wins
    assign sel_b = b_busy_q && (!a_busy_q || !last_q);
    assign gcmd  = sel_b ? b_cmd_q : a_cmd_q;
    assign ack   = wr_req_q ? wr_ack : rd_ack;
    assign tmo   = (cnt_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            drn_q     <= '0;
            a_cmd_q   <= '0;
            b_cmd_q   <= '0;
            a_busy_q  <= 1'b0;
            b_busy_q  <= 1'b0;
            a_done_q  <= 1'b0;
            b_done_q  <= 1'b0;
            err_q     <= 1'b0;
            rdat_q    <= '0;
            rcmp_q    <= '0;
            rmsk_q    <= '0;
            rd_req_q  <= 1'b0;
            wr_req_q  <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wdat_q    <= '0;
            wcmp_q    <= '0;
            wmsk_q    <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            drn_q     <= drn_d;
            a_cmd_q   <= a_cmd_d;
            b_cmd_q   <= b_cmd_d;
            a_busy_q  <= a_busy_d;
            b_busy_q  <= b_busy_d;
            a_done_q  <= a_done_d;
            b_done_q  <= b_done_d;
            err_q     <= err_d;
            rdat_q    <= rdat_d;
            rcmp_q    <= rcmp_d;
            rmsk_q    <= rmsk_d;
            rd_req_q  <= rd_req_d;
            wr_req_q  <= wr_req_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            wdat_q    <= wdat_d;
            wcmp_q    <= wcmp_d;
            wmsk_q    <= wmsk_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        drn_d     = drn_q;
        a_cmd_d   = a_cmd_q;
        b_cmd_d   = b_cmd_q;
        a_busy_d  = a_busy_q;
        b_busy_d  = b_busy_q;
        a_done_d  = 1'b0;
        b_done_d  = 1'b0;
        err_d     = err_q;
        rdat_d    = rdat_q;
        rcmp_d    = rcmp_q;
        rmsk_d    = rmsk_q;
        rd_req_d  = rd_req_q;
        wr_req_d  = wr_req_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        wdat_d    = wdat_q;
        wcmp_d    = wcmp_q;
        wmsk_d    = wmsk_q;

        if (a_req && !a_busy_q) begin
            a_busy_d = 1'b1;
            a_cmd_d  = {a_wr, a_addr, a_wr_data, a_wr_cmp_data, a_wr_cmp_dmask};
        end
        if (b_req && !b_busy_q) begin
            b_busy_d = 1'b1;
            b_cmd_d  = {b_wr, b_addr, b_wr_data, b_wr_cmp_data, b_wr_cmp_dmask};
        end

        unique case (state_q)
            IDLE: begin
                if (a_busy_q || b_busy_q) begin
                    last_d  = sel_b;
                    cnt_d   = '0;
                    state_d = ISSUE;
                    if (gcmd.wr) begin
                        wr_req_d  = 1'b1;
                        wr_addr_d = gcmd.addr;
                        wdat_d    = gcmd.data;
                        wcmp_d    = gcmd.cmp;
                        wmsk_d    = gcmd.msk;
                    end else begin
                        rd_req_d  = 1'b1;
                        rd_addr_d = gcmd.addr;
                    end
                end
            end
            ISSUE: begin
                if (ack || tmo) begin
                    state_d  = DONE;
                    rd_req_d = 1'b0;
                    wr_req_d = 1'b0;
                    err_d    = !ack;
                    if (last_q) begin
                        b_done_d = 1'b1;
                        b_busy_d = 1'b0;
                    end else begin
                        a_done_d = 1'b1;
                        a_busy_d = 1'b0;
                    end
                    if (!ack) begin
                        rdat_d = '0;
                        rcmp_d = '0;
                        rmsk_d = '0;
                    end else if (rd_req_q) begin
                        rdat_d = rd_data;
                        rcmp_d = rd_cmp_data;
                        rmsk_d = rd_cmp_dmask;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = DRAIN;
                drn_d   = '0;
            end
            DRAIN: begin
                if (drn_q == DW'(DRAIN_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    drn_d = drn_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign a_busy        = a_busy_q;
    assign b_busy        = b_busy_q;
    assign a_done        = a_done_q;
    assign b_done        = b_done_q;
    assign res_err       = err_q;
    assign res_data      = rdat_q;
    assign res_cmp_data  = rcmp_q;
    assign res_cmp_dmask = rmsk_q;
    assign rd_req        = rd_req_q;
    assign rd_addr       = rd_addr_q;
    assign wr_req        = wr_req_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wdat_q;
    assign wr_cmp_data   = wcmp_q;
    assign wr_cmp_dmask  = wmsk_q;

endmodule

// File: tb/tb_cam_lut_access_arb.sv
// Bench for cam_lut_access_arb: transaction-level model checked every cycle,
// a scripted controller, and literal latency/result pins.
module tb_cam_lut_access_arb;

    localparam int TO = 64;
    localparam int DR = 4;

    typedef struct packed {
        logic        wr;
        logic [3:0]  addr;
        logic [55:0] d;
        logic [31:0] c;
        logic [31:0] m;
    } cmd_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic a_req = 0, a_wr = 0, b_req = 0, b_wr = 0;
    logic [3:0] a_addr = 0, b_addr = 0;
    logic [55:0] a_wr_data = 0, b_wr_data = 0;
    logic [31:0] a_wr_cmp_data = 0, b_wr_cmp_data = 0;
    logic [31:0] a_wr_cmp_dmask = 0, b_wr_cmp_dmask = 0;
    logic a_busy, b_busy, a_done, b_done, res_err;
    logic [55:0] res_data;
    logic [31:0] res_cmp_data, res_cmp_dmask;
    logic rd_req, wr_req;
    logic [3:0] rd_addr, wr_addr;
    logic rd_ack = 0, wr_ack = 0;
    logic [55:0] rd_data = 0;
    logic [31:0] rd_cmp_data = 0, rd_cmp_dmask = 0;
    logic [55:0] wr_data;
    logic [31:0] wr_cmp_data, wr_cmp_dmask;

    always #5 clk = ~clk;

    cam_lut_access_arb dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr),
        .a_wr_data(a_wr_data), .a_wr_cmp_data(a_wr_cmp_data),
        .a_wr_cmp_dmask(a_wr_cmp_dmask),
        .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr),
        .b_wr_data(b_wr_data), .b_wr_cmp_data(b_wr_cmp_data),
        .b_wr_cmp_dmask(b_wr_cmp_dmask),
        .a_busy(a_busy), .b_busy(b_busy), .a_done(a_done), .b_done(b_done),
        .res_err(res_err), .res_data(res_data),
        .res_cmp_data(res_cmp_data), .res_cmp_dmask(res_cmp_dmask),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_data(rd_data), .rd_cmp_data(rd_cmp_data),
        .rd_cmp_dmask(rd_cmp_dmask),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_cmp_data(wr_cmp_data), .wr_cmp_dmask(wr_cmp_dmask),
        .wr_ack(wr_ack)
    );

    int pass_cnt = 0;
    int chk_cnt = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [254:0] got,
                       input logic [254:0] exp);
        chk_cnt++;
        if (got !== exp)
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
        else
            pass_cnt++;
    endtask

    // inputs as sampled by the DUT at the latest rising edge
    logic p_reset = 1'b1;
    logic p_areq = 0, p_breq = 0, p_rdack = 0, p_wrack = 0;
    cmd_t p_a, p_b;
    logic [55:0] p_rdd;
    logic [31:0] p_rdc, p_rdm;

    initial forever begin
        @(posedge clk);
        cyc++;
        p_reset = reset;
        p_areq = a_req;
        p_breq = b_req;
        p_a = {a_wr, a_addr, a_wr_data, a_wr_cmp_data, a_wr_cmp_dmask};
        p_b = {b_wr, b_addr, b_wr_data, b_wr_cmp_data, b_wr_cmp_dmask};
        p_rdack = rd_ack;
        p_wrack = wr_ack;
        p_rdd = rd_data;
        p_rdc = rd_cmp_data;
        p_rdm = rd_cmp_dmask;
    end

    // model: pending flags, one in-flight op with its start cycle,
    // and the first cycle the arbiter is free to grant again
    logic [1:0] m_busy;
    cmd_t m_cmd [2];
    logic m_last, m_fl, m_who, m_wr;
    int m_start, m_free;
    logic e_ad, e_bd, e_err, e_rd, e_wr;
    logic [3:0] e_ra, e_wa;
    logic [55:0] e_rdat, e_wdat;
    logic [31:0] e_rcmp, e_rmsk, e_wcmp, e_wmsk;

    // monitors used by the literal pins
    int rise_cyc = -1000, hi_cnt = 0, a_dcnt = 0, b_dcnt = 0;
    int a_dcyc = 0, b_dcyc = 0;
    logic [3:0] rise_ra = 0;
    logic rise_wr = 0, prev_req = 0, l_err = 0;
    logic [55:0] l_dat = 0;
    int order[$];

    initial forever begin
        logic [1:0] ob;
        logic hit, who;
        int n;
        @(negedge clk);
        n = cyc;
        ob = m_busy;
        e_ad = 0;
        e_bd = 0;
        if (p_reset) begin
            m_busy = 0; m_last = 1; m_fl = 0; m_free = n;
            e_err = 0; e_rd = 0; e_wr = 0; e_ra = 0; e_wa = 0;
            e_rdat = 0; e_rcmp = 0; e_rmsk = 0;
            e_wdat = 0; e_wcmp = 0; e_wmsk = 0;
        end else begin
            if (m_fl) begin
                hit = m_wr ? p_wrack : p_rdack;
                if (hit || (n - 1 - m_start == TO - 1)) begin
                    m_fl = 0;
                    m_busy[m_who] = 0;
                    if (m_who) e_bd = 1; else e_ad = 1;
                    e_err = !hit;
                    e_rd = 0;
                    e_wr = 0;
                    if (!hit) begin
                        e_rdat = 0; e_rcmp = 0; e_rmsk = 0;
                    end else if (!m_wr) begin
                        e_rdat = p_rdd; e_rcmp = p_rdc; e_rmsk = p_rdm;
                    end
                    m_free = n + DR + 1;
                end
            end else if (n - 1 >= m_free && ob != 0) begin
                who = (ob == 2'b11) ? !m_last : ob[1];
                m_last = who;
                m_fl = 1;
                m_who = who;
                m_start = n;
                m_wr = m_cmd[who].wr;
                if (m_wr) begin
                    e_wr = 1; e_wa = m_cmd[who].addr;
                    e_wdat = m_cmd[who].d;
                    e_wcmp = m_cmd[who].c;
                    e_wmsk = m_cmd[who].m;
                end else begin
                    e_rd = 1; e_ra = m_cmd[who].addr;
                end
            end
            if (p_areq && !ob[0]) begin m_busy[0] = 1; m_cmd[0] = p_a; end
            if (p_breq && !ob[1]) begin m_busy[1] = 1; m_cmd[1] = p_b; end
        end
        chk("cycle",
            {a_busy, b_busy, a_done, b_done, res_err, rd_req, wr_req,
             rd_addr, wr_addr, res_data, res_cmp_data, res_cmp_dmask,
             wr_data, wr_cmp_data, wr_cmp_dmask},
            {m_busy[0], m_busy[1], e_ad, e_bd, e_err, e_rd, e_wr,
             e_ra, e_wa, e_rdat, e_rcmp, e_rmsk,
             e_wdat, e_wcmp, e_wmsk});
        if ((rd_req || wr_req) && !prev_req) begin
            rise_cyc = n; rise_ra = rd_addr; rise_wr = wr_req; hi_cnt = 0;
        end
        if (rd_req || wr_req) hi_cnt++;
        prev_req = rd_req || wr_req;
        if (a_done) begin
            a_dcnt++; a_dcyc = n; order.push_back(0);
            l_err = res_err; l_dat = res_data;
        end
        if (b_done) begin
            b_dcnt++; b_dcyc = n; order.push_back(1);
            l_err = res_err; l_dat = res_data;
        end
    end

    // scripted controller: acks dly cycles after a request rises, dup extra
    logic ctl_en = 0, frc_wr = 0;
    int ctl_dly = 1, ctl_dup = 0;

    initial forever begin
        int c;
        @(posedge clk);
        #2;
        c = cyc;
        rd_ack = 0;
        wr_ack = frc_wr;
        if (ctl_en && c >= rise_cyc + ctl_dly &&
            c <= rise_cyc + ctl_dly + ctl_dup) begin
            rd_ack = !rise_wr;
            wr_ack = rise_wr;
        end
    end

    task automatic drive(input bit who, input cmd_t c);
        if (who) begin
            b_req = 1; b_wr = c.wr; b_addr = c.addr;
            b_wr_data = c.d; b_wr_cmp_data = c.c; b_wr_cmp_dmask = c.m;
        end else begin
            a_req = 1; a_wr = c.wr; a_addr = c.addr;
            a_wr_data = c.d; a_wr_cmp_data = c.c; a_wr_cmp_dmask = c.m;
        end
    endtask

    task automatic issue(input bit who, input cmd_t c, output int c0);
        @(posedge clk); #1;
        drive(who, c);
        c0 = cyc;
        @(posedge clk); #1;
        a_req = 0; b_req = 0;
    endtask

    task automatic issue2(input cmd_t ca, input cmd_t cb, output int c0);
        @(posedge clk); #1;
        drive(0, ca);
        drive(1, cb);
        c0 = cyc;
        @(posedge clk); #1;
        a_req = 0; b_req = 0;
    endtask

    task automatic wait_done(input bit who, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (who ? b_done : a_done) begin
                #1;
                return;
            end
        end
        chk_cnt++;
        $display("FAIL wait_done who=%0d no done within %0d cycles", who, budget);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
    endtask

    initial begin
        int c0, base, ad;
        cmd_t c;
        repeat (3) @(posedge clk);
        #1;
        reset = 0;
        @(negedge clk);
        chk("reset outs", {a_busy, b_busy, rd_req, wr_req, res_err}, 0);

        // write alone
        ctl_en = 1; ctl_dly = 1; ctl_dup = 0;
        c = {1'b1, 4'd5, 56'hABCDEF01234567, 32'hDEADBEEF, 32'h0000FFFF};
        issue(0, c, c0);
        wait_done(0, 40);
        chk("wr rise", rise_cyc - c0, 2);
        chk("wr high cycles", hi_cnt, 2);
        chk("wr done lat", a_dcyc - c0, 4);
        chk("wr err", l_err, 0);
        idle(DR + 2);

        // read alone with duplicate acks
        ctl_dly = 3; ctl_dup = 3;
        rd_data = 56'h11223344556677;
        rd_cmp_data = 32'hCAFEF00D;
        rd_cmp_dmask = 32'h0F0F0F0F;
        base = b_dcnt;
        c = {1'b0, 4'd3, 56'h0, 32'h0, 32'h0};
        issue(1, c, c0);
        wait_done(1, 40);
        chk("rd done lat", b_dcyc - c0, 6);
        chk("rd data", l_dat, 56'h11223344556677);
        idle(12);
        chk("rd single done", b_dcnt - base, 1);

        // simultaneous requests after reset, then alternation
        do_reset();
        ctl_dly = 1; ctl_dup = 0;
        base = order.size();
        issue2({1'b1, 4'd1, 56'h1, 32'h1, 32'h1},
               {1'b1, 4'd2, 56'h2, 32'h2, 32'h2}, c0);
        wait_done(0, 40);
        ad = a_dcyc;
        wait_done(1, 40);
        chk("pair1 first", order[base], 0);
        chk("pair1 second", order[base+1], 1);
        chk("pair1 b gap", rise_cyc - ad, DR + 2);
        idle(DR + 2);
        issue(0, {1'b1, 4'd6, 56'h6, 32'h6, 32'h6}, c0);
        wait_done(0, 40);
        idle(DR + 2);
        base = order.size();
        issue2({1'b1, 4'd7, 56'h7, 32'h7, 32'h7},
               {1'b1, 4'd8, 56'h8, 32'h8, 32'h8}, c0);
        wait_done(1, 40);
        wait_done(0, 40);
        chk("pair2 first", order[base], 1);
        chk("pair2 second", order[base+1], 0);
        idle(DR + 2);

        // timeout on a read
        ctl_en = 0;
        issue(0, {1'b0, 4'd7, 56'h0, 32'h0, 32'h0}, c0);
        wait_done(0, 200);
        chk("tmo high cycles", hi_cnt, TO);
        chk("tmo err", l_err, 1);
        chk("tmo data", l_dat, 0);
        chk("tmo lat", a_dcyc - c0, TO + 2);
        idle(DR + 2);

        // busy request ignored, request in done cycle accepted
        ctl_en = 1; ctl_dly = 3; ctl_dup = 0;
        issue(0, {1'b0, 4'd9, 56'h0, 32'h0, 32'h0}, c0);
        issue(0, {1'b0, 4'd12, 56'h0, 32'h0, 32'h0}, c0);
        wait_done(0, 40);
        chk("busy ignored addr", rise_ra, 9);
        base = a_dcnt;
        drive(0, {1'b0, 4'd12, 56'h0, 32'h0, 32'h0});
        @(posedge clk); #1;
        a_req = 0;
        wait_done(0, 40);
        chk("done-cycle req addr", rise_ra, 12);
        chk("done-cycle req done", a_dcnt - base, 1);
        idle(DR + 2);

        // reset while in ISSUE
        ctl_en = 0;
        base = a_dcnt;
        issue(0, {1'b1, 4'd4, 56'h44, 32'h4, 32'h4}, c0);
        for (int k = 0; k < 20 && !wr_req; k++) @(negedge clk);
        idle(3);
        do_reset();
        @(negedge clk);
        chk("reset abort", {wr_req, rd_req, a_busy, a_done}, 0);
        @(posedge clk); #1;
        frc_wr = 1;
        @(posedge clk); #1;
        frc_wr = 0;
        idle(12);
        chk("reset no done", a_dcnt - base, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
